// File: rtl/interlaken_meta_framer_pkg.sv
// Package: interlaken_meta_framer_pkg
// Shared constants and types for the Interlaken metaframe framer.
//   SYNC_WORD    : metaframe synchronisation control word (never scrambled)
//   SSTATE_TYPE  : block type in [63:58] of the scrambler-state control word
//   SKIP_TYPE    : block type in [63:58] of the skip control word (after descramble)
//   HDR_DATA/CTRL: 64B/67B framing header codes; any other header is invalid
//   framer_state_e: framer FSM states
package interlaken_meta_framer_pkg;

    localparam logic [63:0] SYNC_WORD   = 64'h78F6_78F6_78F6_78F6;
    localparam logic [5:0]  SSTATE_TYPE = 6'b001010;
    localparam logic [5:0]  SKIP_TYPE   = 6'b000011;
    localparam logic [1:0]  HDR_DATA    = 2'b01;
    localparam logic [1:0]  HDR_CTRL    = 2'b10;

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StVerify = 2'd1,
        StLocked = 2'd2
    } framer_state_e;

endpackage

// File: rtl/interlaken_meta_framer_if.sv
// Interface: interlaken_meta_framer_if
// Bundles the decoder-side input bus and the framer output bus.
//   DATA_IN/HEADER_IN/LOCKED_IN : word, 2-bit header and block lock from the 64B/67B decoder
//   DATA_OUT/CTRL_OUT/VALID_OUT : descrambled payload word, control flag, qualifier
//   META_LOCKED                 : framer is locked to the metaframe
//   SYNC_ERR/SCRAM_ERR/HDR_ERR  : single-cycle error pulses
// Modports: master = decoder/consumer side, slave = framer.
interface interlaken_meta_framer_if;

    logic [63:0] DATA_IN;
    logic [1:0]  HEADER_IN;
    logic        LOCKED_IN;
    logic [63:0] DATA_OUT;
    logic        CTRL_OUT;
    logic        VALID_OUT;
    logic        META_LOCKED;
    logic        SYNC_ERR;
    logic        SCRAM_ERR;
    logic        HDR_ERR;

    modport master (
        output DATA_IN, HEADER_IN, LOCKED_IN,
        input  DATA_OUT, CTRL_OUT, VALID_OUT, META_LOCKED, SYNC_ERR, SCRAM_ERR, HDR_ERR
    );

    modport slave (
        input  DATA_IN, HEADER_IN, LOCKED_IN,
        output DATA_OUT, CTRL_OUT, VALID_OUT, META_LOCKED, SYNC_ERR, SCRAM_ERR, HDR_ERR
    );

endinterface

// File: rtl/interlaken_meta_framer_lfsr_step.sv
// Module: interlaken_meta_framer_lfsr_step
// Combinational one-word step of the x^58+x^39+1 additive scrambler sequence
// s(n) = s(n-58) ^ s(n-39), unrolled 64 times.
//   state      in  58  last 58 generated bits; state[0] newest, state[57] oldest
//   next_state out 58  last 58 bits after generating 64 more
//   keystream  out 64  the 64 new bits, keystream[63] generated first
module interlaken_meta_framer_lfsr_step (
    input  logic [57:0] state,
    output logic [57:0] next_state,
    output logic [63:0] keystream
);

    logic [57:0] sh;
    logic        fb;

    always_comb begin
        sh        = state;
        fb        = 1'b0;
        keystream = '0;
        for (int i = 63; i >= 0; i--) begin
            // sh[57] is s(n-58), sh[38] is s(n-39)
            fb           = sh[57] ^ sh[38];
            keystream[i] = fb;
            sh           = {sh[56:0], fb};
        end
        next_state = sh;
    end

endmodule

// File: rtl/interlaken_meta_framer.sv
// Module: interlaken_meta_framer
// Metaframe framing and descrambling stage behind the 64B/67B decoder. Hunts for the
// sync word, verifies it at META_LEN spacing, seeds the descrambler from the
// scrambler-state word and emits descrambled payload with sync/state/skip words stripped.
//   USER_CLK        clock
//   SYSTEM_RESET_N  asynchronous active-low reset
//   bus             interlaken_meta_framer_if.slave (decoder input, payload/status output)
// All bus outputs are registered: one cycle from DATA_IN to DATA_OUT and error pulses.
module interlaken_meta_framer
    import interlaken_meta_framer_pkg::*;
#(
    parameter int unsigned META_LEN   = 2048,
    parameter int unsigned LOCK_GOOD  = 4,
    parameter int unsigned LOCK_MISS  = 4,
    parameter int unsigned SCRAM_MISS = 3
) (
    input logic                      USER_CLK,
    input logic                      SYSTEM_RESET_N,
    interlaken_meta_framer_if.slave  bus
);

    localparam int unsigned PosW = $clog2(META_LEN);
    localparam int unsigned CntW = 8;

    framer_state_e   state_q, state_d;
    logic [PosW-1:0] pos_q, pos_d, pos_inc;
    logic [CntW-1:0] good_q, good_d;
    logic [CntW-1:0] miss_q, miss_d;
    logic [CntW-1:0] smiss_q, smiss_d;
    logic [57:0]     lfsr_q, lfsr_d, lfsr_adv;
    logic [63:0]     keystream;

    logic [63:0] data_q, data_d;
    logic        ctrl_q, ctrl_d;
    logic        valid_q, valid_d;
    logic        sync_err_q, sync_err_d;
    logic        scram_err_q, scram_err_d;
    logic        hdr_err_q, hdr_err_d;

    logic        hdr_ctrl, hdr_ok;
    logic        is_sync, is_sstate, is_skip;
    logic        at_pos0, at_pos1;
    logic        drop_lock;
    logic [63:0] plain;

    interlaken_meta_framer_lfsr_step u_lfsr_step (
        .state      (lfsr_q),
        .next_state (lfsr_adv),
        .keystream  (keystream)
    );

    // Sync and scrambler-state words travel unscrambled; everything else is descrambled
    // before classification, so SKIP is recognised on the recovered plaintext.
    assign hdr_ctrl  = (bus.HEADER_IN == HDR_CTRL);
    assign hdr_ok    = hdr_ctrl || (bus.HEADER_IN == HDR_DATA);
    assign is_sync   = hdr_ctrl && (bus.DATA_IN == SYNC_WORD);
    assign is_sstate = hdr_ctrl && (bus.DATA_IN[63:58] == SSTATE_TYPE);
    assign plain     = (is_sync || is_sstate) ? bus.DATA_IN : (bus.DATA_IN ^ keystream);
    assign is_skip   = hdr_ctrl && !is_sync && !is_sstate && (plain[63:58] == SKIP_TYPE);

    assign at_pos0 = (pos_q == '0);
    assign at_pos1 = (pos_q == PosW'(1));
    assign pos_inc = (pos_q == PosW'(META_LEN - 1)) ? '0 : pos_q + PosW'(1);

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        good_d      = good_q;
        miss_d      = miss_q;
        smiss_d     = smiss_q;
        lfsr_d      = (state_q != StHunt) ? lfsr_adv : lfsr_q;
        data_d      = plain;
        ctrl_d      = hdr_ctrl;
        valid_d     = 1'b0;
        sync_err_d  = 1'b0;
        scram_err_d = 1'b0;
        hdr_err_d   = 1'b0;
        drop_lock   = 1'b0;

        if (!bus.LOCKED_IN) begin
            drop_lock = 1'b1;
        end else begin
            hdr_err_d = !hdr_ok;
            unique case (state_q)
                StHunt: begin
                    if (is_sync) begin
                        state_d = StVerify;
                        pos_d   = PosW'(1);
                        good_d  = CntW'(1);
                    end
                end
                StVerify: begin
                    pos_d = pos_inc;
                    if (at_pos0) begin
                        if (!is_sync) begin
                            drop_lock = 1'b1;
                        end else if (good_q == CntW'(LOCK_GOOD - 1)) begin
                            state_d = StLocked;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + CntW'(1);
                        end
                    end else if (at_pos1 && is_sstate) begin
                        lfsr_d = bus.DATA_IN[57:0];
                    end
                end
                StLocked: begin
                    pos_d   = pos_inc;
                    valid_d = hdr_ok && !is_sync && !is_sstate && !is_skip;
                    if (at_pos0) begin
                        if (is_sync) begin
                            miss_d = '0;
                        end else begin
                            sync_err_d = 1'b1;
                            if (miss_q == CntW'(LOCK_MISS - 1)) begin
                                drop_lock = 1'b1;
                            end else begin
                                miss_d = miss_q + CntW'(1);
                            end
                        end
                    end else if (at_pos1) begin
                        // The state word describes the key for the next word (pos 2), so it is
                        // checked against the advanced LFSR; a match is then the same as a load.
                        if (is_sstate && (bus.DATA_IN[57:0] == lfsr_adv)) begin
                            smiss_d = '0;
                        end else begin
                            scram_err_d = 1'b1;
                            if (is_sstate) begin
                                lfsr_d = bus.DATA_IN[57:0];
                            end
                            if (smiss_q == CntW'(SCRAM_MISS - 1)) begin
                                drop_lock = 1'b1;
                            end else begin
                                smiss_d = smiss_q + CntW'(1);
                            end
                        end
                    end
                end
                default: drop_lock = 1'b1;
            endcase
        end

        if (drop_lock) begin
            state_d = StHunt;
            pos_d   = '0;
            good_d  = '0;
            miss_d  = '0;
            smiss_d = '0;
        end
    end

    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            state_q     <= StHunt;
            pos_q       <= '0;
            good_q      <= '0;
            miss_q      <= '0;
            smiss_q     <= '0;
            lfsr_q      <= '0;
            data_q      <= '0;
            ctrl_q      <= 1'b0;
            valid_q     <= 1'b0;
            sync_err_q  <= 1'b0;
            scram_err_q <= 1'b0;
            hdr_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            good_q      <= good_d;
            miss_q      <= miss_d;
            smiss_q     <= smiss_d;
            lfsr_q      <= lfsr_d;
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            valid_q     <= valid_d;
            sync_err_q  <= sync_err_d;
            scram_err_q <= scram_err_d;
            hdr_err_q   <= hdr_err_d;
        end
    end

    assign bus.DATA_OUT    = data_q;
    assign bus.CTRL_OUT    = ctrl_q;
    assign bus.VALID_OUT   = valid_q;
    assign bus.META_LOCKED = (state_q == StLocked);
    assign bus.SYNC_ERR    = sync_err_q;
    assign bus.SCRAM_ERR   = scram_err_q;
    assign bus.HDR_ERR     = hdr_err_q;

endmodule

// File: tb/tb_interlaken_meta_framer.sv
// Testbench: tb_interlaken_meta_framer
// Directed bench for interlaken_meta_framer with META_LEN=16. A transmitter model
// scrambles an incrementing payload with its own bit-sequence LFSR and inserts sync
// and scrambler-state words; every output word is checked against the model.
module tb_interlaken_meta_framer;
    import interlaken_meta_framer_pkg::*;

    logic USER_CLK;
    logic SYSTEM_RESET_N;

    interlaken_meta_framer_if bus ();

    interlaken_meta_framer #(
        .META_LEN   (16),
        .LOCK_GOOD  (4),
        .LOCK_MISS  (4),
        .SCRAM_MISS (3)
    ) dut (
        .USER_CLK       (USER_CLK),
        .SYSTEM_RESET_N (SYSTEM_RESET_N),
        .bus            (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          vcnt  = 0;
    logic [57:0] tx_st = '0;
    logic [63:0] pl    = 64'h0;

    initial USER_CLK = 1'b0;
    always #5 USER_CLK = ~USER_CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1);
    end

    // Returns {next_state, keystream}; state[0] newest bit, keystream[63] first bit.
    function automatic logic [121:0] lfsr_model(input logic [57:0] st);
        logic        seq [0:121];
        logic [57:0] nx;
        logic [63:0] ks;
        for (int k = 0; k < 58; k++) seq[k] = st[57-k];
        for (int n = 58; n < 122; n++) seq[n] = seq[n-58] ^ seq[n-39];
        for (int j = 0; j < 64; j++) ks[63-j] = seq[58+j];
        for (int k = 0; k < 58; k++) nx[57-k] = seq[64+k];
        return {nx, ks};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [63:0] d, input logic [1:0] h, input logic lk);
        bus.DATA_IN   = d;
        bus.HEADER_IN = h;
        bus.LOCKED_IN = lk;
        @(posedge USER_CLK);
        #1;
        if (bus.VALID_OUT === 1'b1) vcnt++;
    endtask

    task automatic tx_word(input logic scr, input logic [63:0] w, input logic [1:0] h,
                           input logic lk);
        logic [121:0] r;
        r     = lfsr_model(tx_st);
        tx_st = r[121:64];
        drive(scr ? (w ^ r[63:0]) : w, h, lk);
    endtask

    task automatic tx_sstate(input logic force_seed, input logic corrupt);
        logic [121:0] r;
        r     = lfsr_model(tx_st);
        tx_st = force_seed ? 58'h1 : (corrupt ? (r[121:64] ^ 58'h5) : r[121:64]);
        drive({SSTATE_TYPE, tx_st}, HDR_CTRL, 1'b1);
    endtask

    task automatic expect_out(input string tag, input logic ml, input logic se, input logic sce,
                              input logic he, input logic v, input logic c,
                              input logic [63:0] d);
        chk({tag, "/locked"}, {63'h0, bus.META_LOCKED}, {63'h0, ml});
        chk({tag, "/sync_err"}, {63'h0, bus.SYNC_ERR}, {63'h0, se});
        chk({tag, "/scram_err"}, {63'h0, bus.SCRAM_ERR}, {63'h0, sce});
        chk({tag, "/hdr_err"}, {63'h0, bus.HDR_ERR}, {63'h0, he});
        chk({tag, "/valid"}, {63'h0, bus.VALID_OUT}, {63'h0, v});
        if (v) begin
            chk({tag, "/ctrl"}, {63'h0, bus.CTRL_OUT}, {63'h0, c});
            chk({tag, "/data"}, bus.DATA_OUT, d);
        end
    endtask

    task automatic expect_reset(input string tag);
        chk({tag, "/data_out"}, bus.DATA_OUT, 64'h0);
        chk({tag, "/ctrl_out"}, {63'h0, bus.CTRL_OUT}, 64'h0);
        expect_out(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    // One 16-word metaframe. ml_* are META_LOCKED after the sync / state word; pre_locked
    // is whether the framer was LOCKED while the pos-0 word was presented.
    task automatic run_frame(input logic force_seed, input logic bad_sync, input logic bad_ss,
                             input logic special, input logic drop, input logic pre_locked,
                             input logic ml_sync, input logic serr, input logic ml_ss,
                             input logic scerr);
        logic        live, v, he, c;
        logic [63:0] w;
        logic [1:0]  h;
        if (bad_sync) begin
            tx_word(1'b1, pl, HDR_DATA, 1'b1);
            expect_out("pos0", ml_sync, serr, 1'b0, 1'b0, pre_locked, 1'b0, pl);
            pl++;
        end else begin
            tx_word(1'b0, SYNC_WORD, HDR_CTRL, 1'b1);
            expect_out("pos0", ml_sync, serr, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        end
        tx_sstate(force_seed, bad_ss);
        expect_out("pos1", ml_ss, 1'b0, scerr, 1'b0, 1'b0, 1'b0, 64'h0);
        live = ml_ss;
        for (int p = 2; p < 16; p++) begin
            w  = pl;
            h  = HDR_DATA;
            v  = live;
            he = 1'b0;
            c  = 1'b0;
            if (special && p == 5) begin
                w = {SKIP_TYPE, 58'h0};
                h = HDR_CTRL;
                v = 1'b0;
            end else if (special && p == 7) begin
                h  = 2'b11;
                v  = 1'b0;
                he = 1'b1;
            end else if (special && p == 9) begin
                w = 64'h8000_0000_0000_00A5;
                h = HDR_CTRL;
                c = 1'b1;
            end
            if (drop && p == 4) begin
                tx_word(1'b1, w, h, 1'b0);
                live = 1'b0;
                v    = 1'b0;
            end else begin
                tx_word(1'b1, w, h, 1'b1);
            end
            expect_out($sformatf("pos%0d", p), live, 1'b0, 1'b0, he, v, c, w);
            pl++;
        end
    endtask

    task automatic acquire();
        repeat (3) run_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_frame(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    endtask

    initial begin
        SYSTEM_RESET_N = 1'b0;
        bus.DATA_IN    = '0;
        bus.HEADER_IN  = HDR_DATA;
        bus.LOCKED_IN  = 1'b1;
        repeat (2) @(posedge USER_CLK);
        #1;
        expect_reset("reset");
        SYSTEM_RESET_N = 1'b1;

        // Clean stream from seed 1: lock on the 4th sync, then a full locked frame.
        run_frame(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) run_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_frame(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        vcnt = 0;
        run_frame(0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        chk("valid_count", 64'(vcnt), 64'd14);

        // Three missed syncs hold lock, a good one clears, four in a row drop it.
        repeat (3) run_frame(0, 1, 0, 0, 0, 1, 1, 1, 1, 0);
        run_frame(0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        repeat (3) run_frame(0, 1, 0, 0, 0, 1, 1, 1, 1, 0);
        run_frame(0, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        acquire();

        // Two state mismatches then a match hold lock; three in a row drop it.
        repeat (2) run_frame(0, 0, 1, 0, 0, 1, 1, 0, 1, 1);
        run_frame(0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        repeat (2) run_frame(0, 0, 1, 0, 0, 1, 1, 0, 1, 1);
        run_frame(0, 0, 1, 0, 0, 1, 1, 0, 0, 1);
        acquire();

        // Skip word, invalid header and a control payload word inside a locked frame.
        run_frame(0, 0, 0, 1, 0, 1, 1, 0, 1, 0);

        // Decoder lock drops for one word: silent return to hunt, then relock.
        run_frame(0, 0, 0, 0, 1, 1, 1, 0, 1, 0);
        acquire();

        // Reset in the middle of a locked frame clears outputs without a clock edge.
        tx_word(1'b0, SYNC_WORD, HDR_CTRL, 1'b1);
        expect_out("mid_sync", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        tx_sstate(1'b0, 1'b0);
        expect_out("mid_ss", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        tx_word(1'b1, pl, HDR_DATA, 1'b1);
        expect_out("mid_pay", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, pl);
        pl++;
        SYSTEM_RESET_N = 1'b0;
        #2;
        expect_reset("mid_reset");
        repeat (2) @(posedge USER_CLK);
        #1;
        SYSTEM_RESET_N = 1'b1;
        acquire();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
